// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external WIDTHxWIDTH multiplier between two requesters.
// Optional macro MULT_SHARE_RESULT_PIPE_EN adds a WAIT state and a product stage.
module mult_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic [2*WIDTH-1:0] product,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

`ifdef MULT_SHARE_RESULT_PIPE_EN
  typedef enum logic [1:0] {
    IDLE, CALC, WAIT, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_t;
`endif

  state_t state, state_next;

  logic grant_en;
  logic grant_sel;
  logic grant_id;
  logic last_grant;
  logic cap_en;

`ifdef MULT_SHARE_RESULT_PIPE_EN
  logic [2*WIDTH-1:0] stage;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, grant selection and result capture strobe
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_sel  = 1'b0;
    cap_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_en   = 1'b1;
          grant_sel  = (req0 && req1) ? ~last_grant : req1;
          state_next = CALC;
        end
      end
`ifdef MULT_SHARE_RESULT_PIPE_EN
      CALC: state_next = WAIT;
      WAIT: begin
        cap_en     = 1'b1;
        state_next = DONE;
      end
`else
      CALC: begin
        cap_en     = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, arbitration history, product capture and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      product    <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
`ifdef MULT_SHARE_RESULT_PIPE_EN
      stage      <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant_en) begin
        mul_a      <= grant_sel ? a1 : a0;
        mul_b      <= grant_sel ? b1 : b0;
        grant_id   <= grant_sel;
        last_grant <= grant_sel;
      end
`ifdef MULT_SHARE_RESULT_PIPE_EN
      if (state == CALC) stage <= mul_p;
      if (cap_en) product <= stage;
`else
      if (cap_en) product <= mul_p;
`endif
      if (cap_en) begin
        done0 <= ~grant_id;
        done1 <= grant_id;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: scoreboard of {requester, product} per done pulse.
// Models the external multiplier combinationally; latency follows the build macro.
module tb_mult_share_arbiter;

  localparam int W = 4;
`ifdef MULT_SHARE_RESULT_PIPE_EN
  localparam int LAT = 2;
  localparam int PERIOD = 4;
`else
  localparam int LAT = 1;
  localparam int PERIOD = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [W-1:0] mul_a, mul_b;
  logic [2*W-1:0] mul_p;
  logic [2*W-1:0] product;
  logic done0, done1, busy;

  int checks = 0;
  int failures = 0;
  logic [2*W:0] sb[$];

  always #5 clk = ~clk;

  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .product(product),
    .done0(done0), .done1(done1),
    .busy(busy)
  );

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = '0; b0 = '0;
    a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (mul_a !== 4'd0) begin
      failures++;
      $display("FAIL reset_mul_a got=%0d exp=0", mul_a);
    end
    if (mul_b !== 4'd0) begin
      failures++;
      $display("FAIL reset_mul_b got=%0d exp=0", mul_b);
    end
    if (product !== 8'd0) begin
      failures++;
      $display("FAIL reset_product got=%0d exp=0", product);
    end
    if (done0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_done0 got=%b exp=0", done0);
    end
    if (done1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_done1 got=%b exp=0", done1);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    int waited;
    int busy_cnt;
    bit got;
    logic [2*W:0] exp;
    do_reset();
    a0 = 4'd3; b0 = 4'd2; req0 = 1'b1;
    sb.push_back({1'b0, 8'd6});
    @(negedge clk);
    checks += 3;
    if (mul_a !== 4'd3) begin
      failures++;
      $display("FAIL single_mul_a got=%0d exp=3", mul_a);
    end
    if (mul_b !== 4'd2) begin
      failures++;
      $display("FAIL single_mul_b got=%0d exp=2", mul_b);
    end
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy got=%b exp=1", busy);
    end
    busy_cnt = busy ? 1 : 0;
    waited = 0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (busy) busy_cnt++;
      checks++;
      if (done1 !== 1'b0) begin
        failures++;
        $display("FAIL single_done1 got=%b exp=0", done1);
      end
      if (done0 === 1'b1) begin
        got = 1;
        req0 = 1'b0;
        exp = sb.pop_front();
        checks++;
        if ({1'b0, product} !== exp) begin
          failures++;
          $display("FAIL single_result got=%h exp=%h",
                   {1'b0, product}, exp);
        end
      end
    end
    checks += 3;
    if (!got) begin
      failures++;
      $display("FAIL single_timeout got=none exp=done0");
      sb.delete();
    end
    if (waited !== LAT) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=%0d", waited, LAT);
    end
    if (busy_cnt !== LAT + 1) begin
      failures++;
      $display("FAIL single_busy_cycles got=%0d exp=%0d",
               busy_cnt, LAT + 1);
    end
    @(negedge clk);
    checks++;
    if ({busy, done0, done1} !== 3'b000) begin
      failures++;
      $display("FAIL single_after got=%b exp=000",
               {busy, done0, done1});
    end
  endtask

  task automatic test_contention();
    int last;
    logic [2*W:0] exp;
    do_reset();
    a0 = 4'd7; b0 = 4'd4;
    a1 = 4'd15; b1 = 4'd15;
    sb.push_back({1'b0, 8'd28});
    sb.push_back({1'b1, 8'hE1});
    req0 = 1'b1; req1 = 1'b1;
    last = -1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      @(negedge clk);
      checks++;
      if (done0 && done1) begin
        failures++;
        $display("FAIL cont_both_done got=11 exp=one-hot");
      end
      if (done0 || done1) begin
        exp = sb.pop_front();
        checks++;
        if ({done1, product} !== exp) begin
          failures++;
          $display("FAIL cont_result got=%h exp=%h",
                   {done1, product}, exp);
        end
        if (last >= 0) begin
          checks++;
          if (i - last !== PERIOD) begin
            failures++;
            $display("FAIL cont_gap got=%0d exp=%0d",
                     i - last, PERIOD);
          end
        end
        last = i;
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL cont_timeout got=%0d exp=0 pending",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic test_alternate();
    int last;
    int n0;
    int n1;
    logic [2*W:0] exp;
    do_reset();
    a0 = 4'd5; b0 = 4'd6;
    a1 = 4'd9; b1 = 4'd11;
    for (int k = 0; k < 3; k++) begin
      sb.push_back({1'b0, 8'd30});
      sb.push_back({1'b1, 8'd99});
    end
    req0 = 1'b1; req1 = 1'b1;
    last = -1; n0 = 0; n1 = 0;
    for (int i = 0; i < 80 && sb.size() > 0; i++) begin
      @(negedge clk);
      checks++;
      if (done0 && done1) begin
        failures++;
        $display("FAIL alt_both_done got=11 exp=one-hot");
      end
      if (done0 || done1) begin
        exp = sb.pop_front();
        checks++;
        if ({done1, product} !== exp) begin
          failures++;
          $display("FAIL alt_result got=%h exp=%h",
                   {done1, product}, exp);
        end
        if (last >= 0) begin
          checks++;
          if (i - last !== PERIOD) begin
            failures++;
            $display("FAIL alt_gap got=%0d exp=%0d",
                     i - last, PERIOD);
          end
        end
        last = i;
        if (done0) begin
          n0++;
          if (n0 == 3) req0 = 1'b0;
        end
        if (done1) begin
          n1++;
          if (n1 == 3) req1 = 1'b0;
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL alt_timeout got=%0d exp=0 pending",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic test_rr_after_single();
    logic [2*W:0] exp;
    do_reset();
    a1 = 4'd0; b1 = 4'd9; req1 = 1'b1;
    sb.push_back({1'b1, 8'd0});
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        exp = sb.pop_front();
        checks++;
        if ({done1, product} !== exp) begin
          failures++;
          $display("FAIL rr_zero got=%h exp=%h",
                   {done1, product}, exp);
        end
        if (done1) req1 = 1'b0;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rr_zero_timeout got=%0d exp=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    a0 = 4'd2; b0 = 4'd8;
    a1 = 4'd3; b1 = 4'd5;
    sb.push_back({1'b0, 8'd16});
    sb.push_back({1'b1, 8'd15});
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      @(negedge clk);
      checks++;
      if (done0 && done1) begin
        failures++;
        $display("FAIL rr_both_done got=11 exp=one-hot");
      end
      if (done0 || done1) begin
        exp = sb.pop_front();
        checks++;
        if ({done1, product} !== exp) begin
          failures++;
          $display("FAIL rr_order got=%h exp=%h",
                   {done1, product}, exp);
        end
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rr_timeout got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_mid_reset();
    int waited;
    bit got;
    logic [2*W:0] exp;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    a0 = 4'd5; b0 = 4'd5; req0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done0, mul_a} !== {2'b10, 4'd5}) begin
      failures++;
      $display("FAIL midrst_calc got=%b exp=%b",
               {busy, done0, mul_a}, {2'b10, 4'd5});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({done0, done1, busy, product, mul_a} !== 15'd0) begin
      failures++;
      $display("FAIL midrst_clear got=%b exp=0",
               {done0, done1, busy, product, mul_a});
    end
    sb.push_back({1'b0, 8'd25});
    waited = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (done0 || done1) begin
        got = 1;
        req0 = 1'b0;
        exp = sb.pop_front();
        checks++;
        if ({done1, product} !== exp) begin
          failures++;
          $display("FAIL midrst_result got=%h exp=%h",
                   {done1, product}, exp);
        end
      end
    end
    checks += 2;
    if (!got) begin
      failures++;
      $display("FAIL midrst_timeout got=none exp=done0");
      sb.delete();
    end
    if (waited !== LAT + 1) begin
      failures++;
      $display("FAIL midrst_latency got=%0d exp=%0d",
               waited, LAT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_alternate();
    test_rr_after_single();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
